addr_sequencer: RTL and testbench

- Parametrised addressing-mode sequencer for the 6502-compatible NES CPU core.
- Owns the program counter, the instruction register and the bus address.
- Walks every cc=01 addressing mode cycle by cycle: immediate, zp, zp,X, abs, abs,X, abs,Y, (zp,X), (zp),Y.
- Presents a one-cycle operand strobe at the effective address. Register file and ALU consume that strobe.
- Replaces the hard-wired DECODE/FETCH/ABS1/ABS2 controller with full mode coverage, indexing, stall support and optional page-cross penalty.

---
 rtl/addr_sequencer_if.sv | 23 ++
 rtl/addr_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_addr_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/addr_sequencer_if.sv
// Bus bundle between the addressing-mode sequencer (master) and the CPU core / memory side (slave).
interface addr_sequencer_if;
    logic        ready;
    logic [7:0]  d_in;
    logic [7:0]  x_idx;
    logic [7:0]  y_idx;
    logic [15:0] addr;
    logic        sync;
    logic        op_valid;
    logic [7:0]  ir;
    logic [15:0] ea;
    logic [15:0] pc;

    modport master (
        input  ready, d_in, x_idx, y_idx,
        output addr, sync, op_valid, ir, ea, pc
    );

    modport slave (
        output ready, d_in, x_idx, y_idx,
        input  addr, sync, op_valid, ir, ea, pc
    );
endinterface

// File: rtl/addr_sequencer.sv
// 6502 cc=01 addressing-mode sequencer (PC, IR, bus address); one bus cycle per state, all outputs registered.
// ready=0 freezes state and outputs. ADDR_SEQ_PAGE_PENALTY_EN inserts a FIX dummy read on indexed page crossings.
module addr_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter bit          ZP_WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    addr_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        T0, OP1, OP2, IDX, PTRL, PTRH, FIX, DATA, IMPL
    } state_t;

    state_t      state_q;
    logic [15:0] pc_q;
    logic [15:0] addr_q;
    logic [15:0] ea_q;
    logic [7:0]  ir_q;
    logic [7:0]  adl_q;
    logic [7:0]  adh_q;
    logic        sync_q;
    logic        op_valid_q;

    logic [2:0]  bbb;
    logic [15:0] pc_inc;
    logic [8:0]  zp_sum;
    logic [15:0] zp_ea;
    logic [15:0] ptr_next;
    logic [7:0]  ix_idx;
    logic [8:0]  ix_sum;

    assign bbb      = ir_q[4:2];
    assign pc_inc   = pc_q + 16'h0001;
    assign zp_sum   = {1'b0, adl_q} + {1'b0, bus.x_idx};
    assign zp_ea    = ZP_WRAP ? {8'h00, zp_sum[7:0]} : {7'h00, zp_sum};
    assign ptr_next = ZP_WRAP ? {8'h00, adl_q + 8'h01} : ({adh_q, adl_q} + 16'h0001);
    // (zp),Y reaches the indexed add from PTRH with bbb=100, so it selects Y here.
    assign ix_idx   = (bbb == 3'b111) ? bus.x_idx : bus.y_idx;
    assign ix_sum   = {1'b0, adl_q} + {1'b0, ix_idx};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= T0;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            sync_q     <= 1'b1;
            op_valid_q <= 1'b0;
            ir_q       <= 8'hEA;
            ea_q       <= 16'h0000;
            adl_q      <= 8'h00;
            adh_q      <= 8'h00;
        end else if (bus.ready) begin
            sync_q     <= 1'b0;
            op_valid_q <= 1'b0;
            case (state_q)
                T0: begin
                    ir_q   <= bus.d_in;
                    pc_q   <= pc_inc;
                    addr_q <= pc_inc;
                    if (bus.d_in[1:0] != 2'b01) begin
                        state_q <= IMPL;
                    end else if (bus.d_in[4:2] == 3'b010) begin
                        state_q    <= DATA;
                        op_valid_q <= 1'b1;
                        ea_q       <= pc_inc;
                    end else begin
                        state_q <= OP1;
                    end
                end
                OP1: begin
                    pc_q  <= pc_inc;
                    adl_q <= bus.d_in;
                    adh_q <= 8'h00;
                    case (bbb)
                        3'b001: begin
                            state_q    <= DATA;
                            op_valid_q <= 1'b1;
                            addr_q     <= {8'h00, bus.d_in};
                            ea_q       <= {8'h00, bus.d_in};
                        end
                        3'b101, 3'b000: begin
                            state_q <= IDX;
                            addr_q  <= {8'h00, bus.d_in};
                        end
                        3'b100: begin
                            state_q <= PTRL;
                            addr_q  <= {8'h00, bus.d_in};
                        end
                        default: begin
                            state_q <= OP2;
                            addr_q  <= pc_inc;
                        end
                    endcase
                end
                IDX: begin
                    adl_q  <= zp_ea[7:0];
                    adh_q  <= zp_ea[15:8];
                    addr_q <= zp_ea;
                    if (bbb == 3'b101) begin
                        state_q    <= DATA;
                        op_valid_q <= 1'b1;
                        ea_q       <= zp_ea;
                    end else begin
                        state_q <= PTRL;
                    end
                end
                PTRL: begin
                    adl_q   <= bus.d_in;
                    addr_q  <= ptr_next;
                    state_q <= PTRH;
                end
                // OP2 ends abs / abs,X / abs,Y; PTRH ends (zp,X) / (zp),Y. bbb[2] marks the indexed forms.
                OP2, PTRH: begin
                    if (state_q == OP2) begin
                        pc_q <= pc_inc;
                    end
                    if (!bbb[2]) begin
                        adh_q      <= bus.d_in;
                        state_q    <= DATA;
                        op_valid_q <= 1'b1;
                        addr_q     <= {bus.d_in, adl_q};
                        ea_q       <= {bus.d_in, adl_q};
                    end else begin
                        adl_q <= ix_sum[7:0];
`ifdef ADDR_SEQ_PAGE_PENALTY_EN
                        adh_q <= bus.d_in;
                        if (ix_sum[8]) begin
                            state_q <= FIX;
                            addr_q  <= {bus.d_in, ix_sum[7:0]};
                        end else begin
                            state_q    <= DATA;
                            op_valid_q <= 1'b1;
                            addr_q     <= {bus.d_in, ix_sum[7:0]};
                            ea_q       <= {bus.d_in, ix_sum[7:0]};
                        end
`else
                        adh_q      <= bus.d_in + {7'h00, ix_sum[8]};
                        state_q    <= DATA;
                        op_valid_q <= 1'b1;
                        addr_q     <= {bus.d_in + {7'h00, ix_sum[8]}, ix_sum[7:0]};
                        ea_q       <= {bus.d_in + {7'h00, ix_sum[8]}, ix_sum[7:0]};
`endif
                    end
                end
                FIX: begin
                    adh_q      <= adh_q + 8'h01;
                    state_q    <= DATA;
                    op_valid_q <= 1'b1;
                    addr_q     <= {adh_q + 8'h01, adl_q};
                    ea_q       <= {adh_q + 8'h01, adl_q};
                end
                DATA: begin
                    state_q <= T0;
                    sync_q  <= 1'b1;
                    if (bbb == 3'b010) begin
                        pc_q   <= pc_inc;
                        addr_q <= pc_inc;
                    end else begin
                        addr_q <= pc_q;
                    end
                end
                default: begin
                    state_q <= T0;
                    sync_q  <= 1'b1;
                    addr_q  <= pc_q;
                end
            endcase
        end
    end

    assign bus.addr     = addr_q;
    assign bus.sync     = sync_q;
    assign bus.op_valid = op_valid_q;
    assign bus.ir       = ir_q;
    assign bus.ea       = ea_q;
    assign bus.pc       = pc_q;

endmodule

// File: tb/tb_addr_sequencer.sv
// Bench: two sequencers (ZP_WRAP=1 and 0) on a shared memory, checked every cycle against a
// per-instruction model of the 6502 addressing modes, plus directed cases with fixed addresses.
module tb_addr_sequencer;

    typedef struct packed {
        logic [15:0] a;
        logic        s;
        logic        v;
        logic [7:0]  ir;
    } cyc_t;

    typedef struct packed {
        logic [15:0] a;
        logic        s;
        logic        v;
        logic [7:0]  d;
        logic [15:0] pc;
    } obs_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic rdy   = 1'b1;
    logic [7:0] xv = 8'h00;
    logic [7:0] yv = 8'h00;
    logic [7:0] mem [0:65535];

    int checks = 0;
    int errors = 0;

    cyc_t scratch[$];
    cyc_t q0[$];
    cyc_t q1[$];
    obs_t log0[$];
    obs_t log1[$];
    logic [15:0] mpc0, mpc1, mea0, mea1;
    logic [7:0]  mir0, mir1;

    always #5 clk = ~clk;

    addr_sequencer_if bus0();
    addr_sequencer_if bus1();

    assign bus0.ready = rdy;
    assign bus1.ready = rdy;
    assign bus0.x_idx = xv;
    assign bus1.x_idx = xv;
    assign bus0.y_idx = yv;
    assign bus1.y_idx = yv;
    assign bus0.d_in  = mem[bus0.addr];
    assign bus1.d_in  = mem[bus1.addr];

    addr_sequencer #(.RESET_PC(16'h8000), .ZP_WRAP(1'b1)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    addr_sequencer #(.RESET_PC(16'h8000), .ZP_WRAP(1'b0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void put(input logic [15:0] a, input logic s, input logic v, input logic [7:0] irv);
        cyc_t c;
        c.a  = a;
        c.s  = s;
        c.v  = v;
        c.ir = irv;
        scratch.push_back(c);
    endfunction

    function automatic logic [15:0] zp_add(input logic zpw, input logic [7:0] b, input logic [7:0] i);
        logic [8:0] s;
        s = {1'b0, b} + {1'b0, i};
        return zpw ? {8'h00, s[7:0]} : {7'h00, s};
    endfunction

    function automatic logic [15:0] ptr_next(input logic zpw, input logic [15:0] p);
        logic [7:0] lo;
        lo = p[7:0] + 8'h01;
        return zpw ? {8'h00, lo} : p + 16'h0001;
    endfunction

    function automatic void indexed(input logic [15:0] base, input logic [7:0] idx, input logic [7:0] op);
        logic [15:0] full;
        full = base + {8'h00, idx};
`ifdef ADDR_SEQ_PAGE_PENALTY_EN
        if (full[15:8] != base[15:8]) put({base[15:8], full[7:0]}, 1'b0, 1'b0, op);
`endif
        put(full, 1'b0, 1'b1, op);
    endfunction

    // Expected bus cycles of the whole instruction at p, derived from the mode's effective address.
    task automatic model_instr(input logic zpw, inout logic [15:0] p, inout logic [7:0] lir);
        logic [7:0]  op, b, h;
        logic [15:0] pa, pb;
        scratch.delete();
        op = mem[p];
        b  = mem[p + 16'd1];
        h  = mem[p + 16'd2];
        put(p, 1'b1, 1'b0, lir);
        lir = op;
        if (op[1:0] != 2'b01) begin
            put(p + 16'd1, 1'b0, 1'b0, op);
            p = p + 16'd1;
        end else begin
            case (op[4:2])
                3'b010: begin
                    put(p + 16'd1, 1'b0, 1'b1, op);
                    p = p + 16'd2;
                end
                3'b001: begin
                    put(p + 16'd1, 1'b0, 1'b0, op);
                    put({8'h00, b}, 1'b0, 1'b1, op);
                    p = p + 16'd2;
                end
                3'b101: begin
                    put(p + 16'd1, 1'b0, 1'b0, op);
                    put({8'h00, b}, 1'b0, 1'b0, op);
                    put(zp_add(zpw, b, xv), 1'b0, 1'b1, op);
                    p = p + 16'd2;
                end
                3'b011: begin
                    put(p + 16'd1, 1'b0, 1'b0, op);
                    put(p + 16'd2, 1'b0, 1'b0, op);
                    put({h, b}, 1'b0, 1'b1, op);
                    p = p + 16'd3;
                end
                3'b111, 3'b110: begin
                    put(p + 16'd1, 1'b0, 1'b0, op);
                    put(p + 16'd2, 1'b0, 1'b0, op);
                    indexed({h, b}, (op[4:2] == 3'b111) ? xv : yv, op);
                    p = p + 16'd3;
                end
                3'b000: begin
                    put(p + 16'd1, 1'b0, 1'b0, op);
                    put({8'h00, b}, 1'b0, 1'b0, op);
                    pa = zp_add(zpw, b, xv);
                    pb = ptr_next(zpw, pa);
                    put(pa, 1'b0, 1'b0, op);
                    put(pb, 1'b0, 1'b0, op);
                    put({mem[pb], mem[pa]}, 1'b0, 1'b1, op);
                    p = p + 16'd2;
                end
                default: begin
                    put(p + 16'd1, 1'b0, 1'b0, op);
                    pa = {8'h00, b};
                    pb = ptr_next(zpw, pa);
                    put(pa, 1'b0, 1'b0, op);
                    put(pb, 1'b0, 1'b0, op);
                    indexed({mem[pb], mem[pa]}, yv, op);
                    p = p + 16'd2;
                end
            endcase
        end
    endtask

    task automatic cmp_dut(input string n, input cyc_t e, input logic [15:0] a, input logic s,
                           input logic v, input logic [7:0] ir, input logic [15:0] ea,
                           input logic [15:0] pc, inout logic [15:0] mea);
        if (e.v) mea = e.a;
        check({n, ".addr"}, 32'(a), 32'(e.a));
        check({n, ".sync"}, 32'(s), 32'(e.s));
        check({n, ".op_valid"}, 32'(v), 32'(e.v));
        check({n, ".ir"}, 32'(ir), 32'(e.ir));
        check({n, ".ea"}, 32'(ea), 32'(mea));
        if (e.s) check({n, ".pc_at_t0"}, 32'(pc), 32'(e.a));
    endtask

    // One bus cycle: entered and left #1 after a rising edge; outputs sampled on the falling edge.
    task automatic cycle(input logic r);
        cyc_t junk;
        obs_t o;
        rdy = r;
        if (q0.size() == 0) begin
            model_instr(1'b1, mpc0, mir0);
            foreach (scratch[i]) q0.push_back(scratch[i]);
        end
        if (q1.size() == 0) begin
            model_instr(1'b0, mpc1, mir1);
            foreach (scratch[i]) q1.push_back(scratch[i]);
        end
        @(negedge clk);
        cmp_dut("d0", q0[0], bus0.addr, bus0.sync, bus0.op_valid, bus0.ir, bus0.ea, bus0.pc, mea0);
        cmp_dut("d1", q1[0], bus1.addr, bus1.sync, bus1.op_valid, bus1.ir, bus1.ea, bus1.pc, mea1);
        o = '{bus0.addr, bus0.sync, bus0.op_valid, bus0.d_in, bus0.pc};
        log0.push_back(o);
        o = '{bus1.addr, bus1.sync, bus1.op_valid, bus1.d_in, bus1.pc};
        log1.push_back(o);
        @(posedge clk);
        #1;
        if (r) begin
            junk = q0.pop_front();
            junk = q1.pop_front();
        end
    endtask

    task automatic do_reset(input logic [7:0] x, input logic [7:0] y);
        reset = 1'b0;
        rdy   = 1'b1;
        xv    = x;
        yv    = y;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst.addr", 32'(bus0.addr), 32'h8000);
        check("rst.sync", 32'(bus0.sync), 32'h1);
        check("rst.op_valid", 32'(bus0.op_valid), 32'h0);
        check("rst.ir", 32'(bus0.ir), 32'hEA);
        check("rst.ea", 32'(bus0.ea), 32'h0);
        check("rst.pc", 32'(bus0.pc), 32'h8000);
        check("rst.d1.addr", 32'(bus1.addr), 32'h8000);
        q0.delete();
        q1.delete();
        log0.delete();
        log1.delete();
        mpc0 = 16'h8000;
        mpc1 = 16'h8000;
        mir0 = 8'hEA;
        mir1 = 8'hEA;
        mea0 = 16'h0000;
        mea1 = 16'h0000;
        reset = 1'b1;
    endtask

    task automatic load3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        mem[16'h8000] = b0;
        mem[16'h8001] = b1;
        mem[16'h8002] = b2;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        #2;

        // immediate: A9 42
        load3(8'hA9, 8'h42, 8'hEA);
        do_reset(8'h00, 8'h00);
        for (int i = 0; i < 3; i++) cycle(1'b1);
        check("imm.c0", 32'({log0[0].a, 3'b0, log0[0].s}), 32'h80001);
        check("imm.c1", 32'({log0[1].a, 3'b0, log0[1].v}), 32'h80011);
        check("imm.d_in", 32'(log0[1].d), 32'h42);
        check("imm.c2", 32'({log0[2].a, 3'b0, log0[2].s}), 32'h80021);

        // abs,X no page cross: BD 34 12, X=10
        load3(8'hBD, 8'h34, 8'h12);
        do_reset(8'h10, 8'h00);
        for (int i = 0; i < 5; i++) cycle(1'b1);
        check("absx.data", 32'({log0[3].a, 3'b0, log0[3].v}), 32'h12441);
        check("absx.next_t0", 32'({log0[4].a, 3'b0, log0[4].s}), 32'h80031);

        // abs,X page cross: X=F0
        do_reset(8'hF0, 8'h00);
        for (int i = 0; i < 6; i++) cycle(1'b1);
`ifdef ADDR_SEQ_PAGE_PENALTY_EN
        check("absx_pc.fix", 32'({log0[3].a, 3'b0, log0[3].v}), 32'h12240);
        check("absx_pc.data", 32'({log0[4].a, 3'b0, log0[4].v}), 32'h13241);
`else
        check("absx_pc.data", 32'({log0[3].a, 3'b0, log0[3].v}), 32'h13241);
        check("absx_pc.next_t0", 32'({log0[4].a, 3'b0, log0[4].s}), 32'h80031);
`endif

        // (zp,X) with zero-page wrap on the pointer-high fetch: A1 F0, X=0F
        load3(8'hA1, 8'hF0, 8'hEA);
        mem[16'h00FF] = 8'h00;
        mem[16'h0000] = 8'h30;
        do_reset(8'h0F, 8'h00);
        for (int i = 0; i < 7; i++) cycle(1'b1);
        check("izx.idx", 32'(log0[2].a), 32'h00F0);
        check("izx.ptrl", 32'(log0[3].a), 32'h00FF);
        check("izx.ptrh", 32'(log0[4].a), 32'h0000);
        check("izx.data", 32'({log0[5].a, 3'b0, log0[5].v}), 32'h30001);

        // zp,X wrap vs carry into page 1: B5 F0, X=20
        load3(8'hB5, 8'hF0, 8'hEA);
        do_reset(8'h20, 8'h00);
        for (int i = 0; i < 5; i++) cycle(1'b1);
        check("zpx.wrap", 32'({log0[3].a, 3'b0, log0[3].v}), 32'h00101);
        check("zpx.nowrap", 32'({log1[3].a, 3'b0, log1[3].v}), 32'h01101);

        // three stalled cycles in OP2 of AD 00 20
        load3(8'hAD, 8'h00, 8'h20);
        do_reset(8'h00, 8'h00);
        cycle(1'b1);
        cycle(1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0);
        cycle(1'b1);
        cycle(1'b1);
        for (int i = 2; i < 6; i++) begin
            check("stall.addr", 32'(log0[i].a), 32'h8002);
            check("stall.pc", 32'(log0[i].pc), 32'h8002);
        end
        check("stall.data", 32'({log0[6].a, 3'b0, log0[6].v}), 32'h20001);

        // reset asserted in PTRH of B1 10
        load3(8'hB1, 8'h10, 8'hEA);
        do_reset(8'h00, 8'h05);
        for (int i = 0; i < 3; i++) cycle(1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("midrst.addr", 32'(bus0.addr), 32'h8000);
        check("midrst.sync", 32'(bus0.sync), 32'h1);
        check("midrst.op_valid", 32'(bus0.op_valid), 32'h0);
        do_reset(8'h00, 8'h05);
        for (int i = 0; i < 8; i++) cycle(1'b1);

        // random programs, random indices, random stalls
        for (int run = 0; run < 8; run++) begin
            for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
            for (int i = 16'h8000; i < 16'h8200; i++) mem[i] = 8'($urandom);
            do_reset(8'($urandom), 8'($urandom));
            for (int c = 0; c < 400; c++) cycle($urandom_range(0, 3) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
